fb_pixel_fifo: RTL and testbench
================================

FB_PIXEL_FIFO -- requirements
Module: fb_pixel_fifo

Interface
REQ-001 Parameter WRITE_WIDTH, default 128, width of din in bits.
REQ-002 Parameter READ_WIDTH, default 32, width of dout; ratio R = WRITE_WIDTH/READ_WIDTH SHALL be an integer power of two, 4 by default.
REQ-003 Parameter WRITE_DEPTH, default 256, number of WRITE_WIDTH storage words; SHALL be a power of two.
REQ-004 Parameter WR_COUNT_WIDTH, default 9, width of wr_data_count, equal to log2(WRITE_DEPTH)+1.
REQ-005 Parameter RD_COUNT_WIDTH, default 11, width of rd_data_count, equal to WR_COUNT_WIDTH+log2(R).
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 Port wr_en, input, 1 bit: write request for din.
REQ-009 Port din, input, WRITE_WIDTH bits: write word.
REQ-010 Port rd_en, input, 1 bit: read request for one READ_WIDTH lane.
REQ-011 Port dout, output, READ_WIDTH bits: registered read data.
REQ-012 Port data_valid, output, 1 bit: dout updated by a read accepted the previous cycle.
REQ-013 Port full / empty, outputs, 1 bit each: no free write word / no unread lane.
REQ-014 Port overflow / underflow, outputs, 1 bit each: rejected write / rejected read in previous cycle.
REQ-015 Port wr_data_count, output, WR_COUNT_WIDTH bits: occupied write words.
REQ-016 Port rd_data_count, output, RD_COUNT_WIDTH bits: unread lanes.

Function
REQ-017 State: write pointer wp (log2(DEPTH)+1 bits, wrapping) and read lane pointer rp (log2(DEPTH)+log2(R)+1 bits, wrapping); rp upper bits = read word, lower log2(R) bits = lane.
REQ-018 wr_data_count SHALL equal wp - rp[word] (modulo), range 0..DEPTH; a word counts as occupied until its last lane is read.
REQ-019 rd_data_count SHALL equal R*wp - rp (modulo), range 0..R*DEPTH.
REQ-020 full = (wr_data_count == DEPTH); empty = (rd_data_count == 0); both are combinational from registered pointers, so they update the cycle after the causing operation.
REQ-021 Write accepted when wr_en and not full: store din at wp, increment wp; when full, do not write and assert overflow for exactly the next cycle.
REQ-022 Read accepted when rd_en and not empty: on the next edge dout = lane rp[lane] of word rp[word], increment rp, and assert data_valid for that cycle.
REQ-023 When rd_en is asserted while empty, dout and rp SHALL hold, and underflow and data_valid SHALL be 1 and 0 respectively for the next cycle.
REQ-024 Lane order little-endian: lane 0 = din[READ_WIDTH-1:0] is read first, lane R-1 = din[WRITE_WIDTH-1:WRITE_WIDTH-READ_WIDTH] last.
REQ-025 dout SHALL hold its last value when no read is accepted; data_valid SHALL be 0 in those cycles.
REQ-026 Simultaneous accepted read and write both take effect in the same cycle; full and empty are evaluated on pre-edge state, so a write at full is rejected even if the same-cycle read frees a word.
REQ-027 Write to empty FIFO: data readable (empty = 0) the next cycle; no first-word fall-through.
REQ-028 Pointers wrap modulo their width; wrap SHALL not corrupt counts or ordering.
REQ-029 Storage needs no reset; inferable as simple dual-port RAM, 1-cycle read latency.

Reset
REQ-030 While rst = 1, asynchronously: wp = rp = 0, dout = 0, data_valid = 0, overflow = 0, underflow = 0; hence empty = 1, full = 0, both counts = 0.
REQ-031 Reset mid-operation discards all contents; the first accepted operation after deassertion behaves as on a fresh FIFO.

Verification
REQ-032 Reset, write din = 0x44444444_33333333_22222222_11111111 -> next cycle wr_data_count = 1, rd_data_count = 4, empty = 0.
REQ-033 Four consecutive rd_en -> dout 0x11111111, 0x22222222, 0x33333333, 0x44444444 with data_valid = 1 each cycle; then empty = 1 and wr_data_count = 0.
REQ-034 Write 256 words -> full = 1, wr_data_count = 256, rd_data_count = 1024; 257th write -> overflow = 1 for one cycle and contents are unchanged.
REQ-035 rd_en on empty FIFO -> underflow = 1 for one cycle, data_valid = 0, dout unchanged.
REQ-036 Stream 600 words with simultaneous reads (pointer wrap) -> all 2400 lanes emerge in order with no loss, counts never exceed their limits.
REQ-037 Assert rst with 10 words stored -> immediately empty = 1, both counts = 0, dout = 0.

Source files
------------

// File: rtl/fb_pixel_fifo_if.sv
// Pixel FIFO bus: wide write port and narrow read port with status and counts.
interface fb_pixel_fifo_if #(
  parameter int WRITE_WIDTH    = 128,
  parameter int READ_WIDTH     = 32,
  parameter int WR_COUNT_WIDTH = 9,
  parameter int RD_COUNT_WIDTH = 11
);
  logic                      wr_en;
  logic [WRITE_WIDTH-1:0]    din;
  logic                      rd_en;
  logic [READ_WIDTH-1:0]     dout;
  logic                      data_valid;
  logic                      full;
  logic                      empty;
  logic                      overflow;
  logic                      underflow;
  logic [WR_COUNT_WIDTH-1:0] wr_data_count;
  logic [RD_COUNT_WIDTH-1:0] rd_data_count;

  // Producer/consumer side (drives requests, observes data and status)
  modport master (
    output wr_en, din, rd_en,
    input  dout, data_valid, full, empty, overflow, underflow,
           wr_data_count, rd_data_count
  );

  // FIFO side
  modport slave (
    input  wr_en, din, rd_en,
    output dout, data_valid, full, empty, overflow, underflow,
           wr_data_count, rd_data_count
  );
endinterface

// File: rtl/fb_pixel_fifo.sv
// Width-converting synchronous FIFO: WRITE_WIDTH words in, READ_WIDTH lanes out,
// lane 0 (least significant) first. Storage is a simple dual-port RAM with a
// registered one-cycle read; flags come combinationally from the pointers.
module fb_pixel_fifo #(
  parameter int WRITE_WIDTH    = 128,
  parameter int READ_WIDTH     = 32,
  parameter int WRITE_DEPTH    = 256,
  parameter int WR_COUNT_WIDTH = 9,
  parameter int RD_COUNT_WIDTH = 11
) (
  input logic          clk,
  input logic          rst,
  fb_pixel_fifo_if.slave bus
);
  localparam int R         = WRITE_WIDTH / READ_WIDTH;
  localparam int LANE_BITS = $clog2(R);
  localparam int ADDR_BITS = $clog2(WRITE_DEPTH);

  // Storage: one entry per full write word, no reset needed
  logic [WRITE_WIDTH-1:0] r_mem [WRITE_DEPTH];

  // Write pointer counts words; read pointer counts lanes (upper bits = word)
  logic [ADDR_BITS:0]           r_wp;
  logic [ADDR_BITS+LANE_BITS:0] r_rp;
  logic [READ_WIDTH-1:0]        r_dout;
  logic                         r_data_valid;
  logic                         r_overflow;
  logic                         r_underflow;

  logic [ADDR_BITS:0]           w_rd_word;
  logic [LANE_BITS-1:0]         w_rd_lane;
  logic [ADDR_BITS:0]           w_wr_count;
  logic [ADDR_BITS+LANE_BITS:0] w_rd_count;
  logic                         w_full;
  logic                         w_empty;
  logic                         w_wr_accept;
  logic                         w_rd_accept;

  assign w_rd_word = r_rp[ADDR_BITS+LANE_BITS:LANE_BITS];
  assign w_rd_lane = r_rp[LANE_BITS-1:0];

  // A word stays occupied until its last lane has been read, so the word
  // count subtracts the read word index, not a rounded-up lane count.
  assign w_wr_count = r_wp - w_rd_word;
  assign w_rd_count = {r_wp, {LANE_BITS{1'b0}}} - r_rp;

  assign w_full  = (w_wr_count == (ADDR_BITS+1)'(WRITE_DEPTH));
  assign w_empty = (w_rd_count == '0);

  // Acceptance uses pre-edge flags: a write at full is rejected even if a
  // read in the same cycle frees a word.
  assign w_wr_accept = bus.wr_en && !w_full;
  assign w_rd_accept = bus.rd_en && !w_empty;

  // RAM write port
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[r_wp[ADDR_BITS-1:0]] <= bus.din;
    end
  end

  // Pointers, registered read lane, and one-cycle status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp         <= '0;
      r_rp         <= '0;
      r_dout       <= '0;
      r_data_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_data_valid <= w_rd_accept;
      r_overflow   <= bus.wr_en && w_full;
      r_underflow  <= bus.rd_en && w_empty;
      if (w_wr_accept) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_rd_accept) begin
        r_dout <= r_mem[w_rd_word[ADDR_BITS-1:0]][w_rd_lane*READ_WIDTH +: READ_WIDTH];
        r_rp   <= r_rp + 1'b1;
      end
    end
  end

  assign bus.dout          = r_dout;
  assign bus.data_valid    = r_data_valid;
  assign bus.overflow      = r_overflow;
  assign bus.underflow     = r_underflow;
  assign bus.full          = w_full;
  assign bus.empty         = w_empty;
  assign bus.wr_data_count = WR_COUNT_WIDTH'(w_wr_count);
  assign bus.rd_data_count = RD_COUNT_WIDTH'(w_rd_count);
endmodule

// File: tb/tb_fb_pixel_fifo.sv
// Testbench for fb_pixel_fifo: directed scenarios plus a randomized stream,
// all checked against a lane-queue reference model.
module tb_fb_pixel_fifo;
  localparam int WW = 128;
  localparam int RW = 32;
  localparam int R  = WW / RW;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fb_pixel_fifo_if #(.WRITE_WIDTH(WW), .READ_WIDTH(RW),
                     .WR_COUNT_WIDTH(9), .RD_COUNT_WIDTH(11)) bus ();

  fb_pixel_fifo #(.WRITE_WIDTH(WW), .READ_WIDTH(RW), .WRITE_DEPTH(DEPTH),
                  .WR_COUNT_WIDTH(9), .RD_COUNT_WIDTH(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: unread lanes in read order, plus expected outputs
  logic [RW-1:0] model_q [$];
  logic [RW-1:0] exp_dout;
  logic          exp_dv, exp_ovf, exp_unf, exp_full, exp_empty;
  int            exp_wrc, exp_rdc;
  logic          last_wr_acc;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic model_status();
    exp_rdc   = model_q.size();
    exp_wrc   = (model_q.size() + R - 1) / R;
    exp_full  = (exp_wrc == DEPTH);
    exp_empty = (exp_rdc == 0);
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_dout = '0; exp_dv = 0; exp_ovf = 0; exp_unf = 0;
    model_status();
  endtask

  // Drive one clock cycle of requests and advance the model
  task automatic drive_cycle(input logic we, input logic [WW-1:0] d, input logic re);
    logic mfull, mempty;
    mfull  = ((model_q.size() + R - 1) / R) == DEPTH;
    mempty = (model_q.size() == 0);
    bus.wr_en = we; bus.din = d; bus.rd_en = re;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    exp_dv  = re && !mempty;
    exp_ovf = we && mfull;
    exp_unf = re && mempty;
    last_wr_acc = we && !mfull;
    if (re && !mempty) exp_dout = model_q.pop_front();
    if (we && !mfull)
      for (int i = 0; i < R; i++) model_q.push_back(d[i*RW +: RW]);
    model_status();
  endtask

  function automatic logic [WW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({bus.dout, bus.data_valid, bus.overflow, bus.underflow, bus.full, bus.empty,
         bus.wr_data_count, bus.rd_data_count} !==
        {exp_dout, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'd0, 11'd0})
      $display("FAIL reset_state: dout=%h dv=%b ovf=%b unf=%b full=%b empty=%b wrc=%0d rdc=%0d, required dout=0 dv=0 ovf=0 unf=0 full=0 empty=1 counts=0",
               bus.dout, bus.data_valid, bus.overflow, bus.underflow, bus.full, bus.empty,
               bus.wr_data_count, bus.rd_data_count);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    logic [WW-1:0] w;
    logic [RW-1:0] lanes [4];
    w = 128'h44444444_33333333_22222222_11111111;
    lanes = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    drive_cycle(1'b1, w, 1'b0);
    n_checks++;
    if (bus.wr_data_count !== 9'd1 || bus.rd_data_count !== 11'd4 || bus.empty !== 1'b0)
      $display("FAIL single_write: wrc=%0d rdc=%0d empty=%b, required wrc=1 rdc=4 empty=0",
               bus.wr_data_count, bus.rd_data_count, bus.empty);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, '0, 1'b1);
      n_checks++;
      if (bus.dout !== lanes[i] || bus.data_valid !== 1'b1 || bus.dout !== exp_dout)
        $display("FAIL lane_order[%0d]: dout=%h dv=%b, required dout=%h dv=1",
                 i, bus.dout, bus.data_valid, lanes[i]);
      else n_pass++;
    end
    n_checks++;
    if (bus.empty !== 1'b1 || bus.wr_data_count !== 9'd0)
      $display("FAIL drained: empty=%b wrc=%0d, required empty=1 wrc=0",
               bus.empty, bus.wr_data_count);
    else n_pass++;
  endtask

  task automatic test_underflow();
    drive_cycle(1'b0, '0, 1'b1);
    n_checks++;
    if (bus.underflow !== 1'b1 || bus.data_valid !== 1'b0 || bus.dout !== exp_dout)
      $display("FAIL underflow: unf=%b dv=%b dout=%h, required unf=1 dv=0 dout=%h",
               bus.underflow, bus.data_valid, bus.dout, exp_dout);
    else n_pass++;
    drive_cycle(1'b0, '0, 1'b0);
    n_checks++;
    if (bus.underflow !== 1'b0 || bus.dout !== exp_dout || bus.empty !== 1'b1)
      $display("FAIL underflow_pulse: unf=%b dout=%h empty=%b, required unf=0 dout=%h empty=1",
               bus.underflow, bus.dout, bus.empty, exp_dout);
    else n_pass++;
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, rand_word(), 1'b0);
    n_checks++;
    if (bus.full !== 1'b1 || bus.wr_data_count !== 9'd256 || bus.rd_data_count !== 11'd1024)
      $display("FAIL fill: full=%b wrc=%0d rdc=%0d, required full=1 wrc=256 rdc=1024",
               bus.full, bus.wr_data_count, bus.rd_data_count);
    else n_pass++;
    // 257th write is rejected
    drive_cycle(1'b1, {4{32'hDEADBEEF}}, 1'b0);
    n_checks++;
    if (bus.overflow !== 1'b1 || bus.full !== 1'b1 || bus.rd_data_count !== 11'd1024)
      $display("FAIL overflow: ovf=%b full=%b rdc=%0d, required ovf=1 full=1 rdc=1024",
               bus.overflow, bus.full, bus.rd_data_count);
    else n_pass++;
    drive_cycle(1'b0, '0, 1'b0);
    n_checks++;
    if (bus.overflow !== 1'b0)
      $display("FAIL overflow_pulse: ovf=%b, required 0", bus.overflow);
    else n_pass++;
    // Write at full with a simultaneous read: read taken, write still rejected
    drive_cycle(1'b1, {4{32'hCAFEF00D}}, 1'b1);
    n_checks++;
    if (bus.overflow !== 1'b1 || bus.data_valid !== 1'b1 || bus.dout !== exp_dout ||
        bus.rd_data_count !== 11'd1023 || bus.wr_data_count !== 9'd256)
      $display("FAIL full_rw: ovf=%b dv=%b dout=%h rdc=%0d wrc=%0d, required ovf=1 dv=1 dout=%h rdc=1023 wrc=256",
               bus.overflow, bus.data_valid, bus.dout, bus.rd_data_count, bus.wr_data_count, exp_dout);
    else n_pass++;
    // Drain and confirm contents untouched by the rejected writes
    while (model_q.size() != 0) begin
      drive_cycle(1'b0, '0, 1'b1);
      n_checks++;
      if (bus.dout !== exp_dout || bus.data_valid !== 1'b1 ||
          bus.rd_data_count !== 11'(exp_rdc) || bus.wr_data_count !== 9'(exp_wrc))
        $display("FAIL drain: dout=%h dv=%b rdc=%0d wrc=%0d, required dout=%h dv=1 rdc=%0d wrc=%0d",
                 bus.dout, bus.data_valid, bus.rd_data_count, bus.wr_data_count,
                 exp_dout, exp_rdc, exp_wrc);
      else n_pass++;
    end
  endtask

  task automatic test_stream_wrap();
    int wrote, cyc;
    logic we, re;
    wrote = 0; cyc = 0;
    while ((wrote < 600 || model_q.size() != 0) && cyc < 20000) begin
      we = (wrote < 600) && ($urandom_range(0, 3) == 0);
      re = ($urandom_range(0, 9) != 0);
      drive_cycle(we, rand_word(), re);
      if (last_wr_acc) wrote++;
      cyc++;
      n_checks++;
      if (bus.dout !== exp_dout || bus.data_valid !== exp_dv || bus.underflow !== exp_unf ||
          bus.overflow !== exp_ovf || bus.full !== exp_full || bus.empty !== exp_empty ||
          bus.rd_data_count !== 11'(exp_rdc) || bus.wr_data_count !== 9'(exp_wrc))
        $display("FAIL stream[%0d]: dout=%h dv=%b unf=%b ovf=%b full=%b empty=%b rdc=%0d wrc=%0d, required dout=%h dv=%b unf=%b ovf=%b full=%b empty=%b rdc=%0d wrc=%0d",
                 cyc, bus.dout, bus.data_valid, bus.underflow, bus.overflow, bus.full, bus.empty,
                 bus.rd_data_count, bus.wr_data_count, exp_dout, exp_dv, exp_unf, exp_ovf,
                 exp_full, exp_empty, exp_rdc, exp_wrc);
      else n_pass++;
    end
    n_checks++;
    if (cyc >= 20000 || wrote != 600)
      $display("FAIL stream_budget: wrote=%0d cycles=%0d, required 600 words drained within 20000 cycles",
               wrote, cyc);
    else n_pass++;
  endtask

  task automatic test_reset_midway();
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, rand_word(), 1'b0);
    drive_cycle(1'b0, '0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.wr_data_count !== 9'd0 ||
        bus.rd_data_count !== 11'd0 || bus.dout !== 32'd0 || bus.data_valid !== 1'b0)
      $display("FAIL reset_mid: empty=%b full=%b wrc=%0d rdc=%0d dout=%h dv=%b, required empty=1 full=0 counts=0 dout=0 dv=0",
               bus.empty, bus.full, bus.wr_data_count, bus.rd_data_count, bus.dout, bus.data_valid);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // Fresh behaviour after reset
    drive_cycle(1'b1, rand_word(), 1'b0);
    drive_cycle(1'b0, '0, 1'b1);
    n_checks++;
    if (bus.dout !== exp_dout || bus.data_valid !== 1'b1 || bus.rd_data_count !== 11'd3 ||
        bus.wr_data_count !== 9'd1)
      $display("FAIL after_reset: dout=%h dv=%b rdc=%0d wrc=%0d, required dout=%h dv=1 rdc=3 wrc=1",
               bus.dout, bus.data_valid, bus.rd_data_count, bus.wr_data_count, exp_dout);
    else n_pass++;
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = '0;
    last_wr_acc = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_single_word();
    test_underflow();
    test_full_overflow();
    test_underflow();
    test_stream_wrap();
    test_reset_midway();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
